// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared types and timing constants for the byte-serial adder sequencer.
package byte_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Latency of the external registered 8-bit adder; sum/cout for the byte
  // issued in one cycle are visible ADD_LAT cycles later.
  localparam int unsigned ADD_LAT = 1;

endpackage

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial operand sequencer and result collector around an external
// registered 8-bit adder. One byte is issued per cycle, the adder's
// registered carry is chained into the next byte, and the registered sums
// are reassembled into a wide result with carry and signed overflow flags.
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned N_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*N_BYTES-1:0]   in_a,
  input  logic [8*N_BYTES-1:0]   in_b,
  input  logic                   in_sub,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  output logic                   add_cin,
  input  logic [7:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_BYTES-1:0]   out_res,
  output logic                   out_carry,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int unsigned W     = 8 * N_BYTES;
  localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] prev_idx;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             op_sub;
  logic [W-1:0]     res;
  logic             carry;
  logic             ovf;

  assign out_res   = res;
  assign out_carry = carry;
  assign out_ovf   = ovf;

  // Sum arriving now belongs to the byte issued ADD_LAT cycles ago.
  assign prev_idx = idx - IDX_W'(ADD_LAT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state, handshake outputs and adder operand drive.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        add_a   = 8'(op_a >> {idx, 3'b000});
        add_b   = 8'(op_b >> {idx, 3'b000});
        add_cin = (idx == '0) ? op_sub : add_cout;
        if (idx == LAST) next_state = DRAIN;
      end
      DRAIN: next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, byte index and result/flag capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      res    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= in_a;
            op_b   <= in_b ^ {W{in_sub}};
            op_sub <= in_sub;
            idx    <= '0;
          end
        end
        RUN: begin
          if (idx != LAST) idx <= idx + IDX_W'(1);
          if (idx != '0) res[{prev_idx, 3'b000} +: 8] <= add_sum;
        end
        DRAIN: begin
          res[W-8 +: 8] <= add_sum;
          carry         <= add_cout;
          ovf           <= (op_a[W-1] == op_b[W-1]) && (add_sum[7] != op_a[W-1]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed bench for byte_serial_add_ctrl: a 4-byte and a 1-byte instance,
// each paired with a registered 8-bit adder model.
module tb_byte_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // 4-byte instance signals
  logic        in_valid = 1'b0, in_ready, in_sub = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready = 1'b0, out_carry, out_ovf, busy;
  logic [31:0] out_res;

  // 1-byte instance signals
  logic        u1_in_valid = 1'b0, u1_in_ready, u1_in_sub = 1'b0;
  logic [7:0]  u1_in_a = '0, u1_in_b = '0;
  logic [7:0]  u1_add_a, u1_add_b, u1_add_sum;
  logic        u1_add_cin, u1_add_cout;
  logic        u1_out_valid, u1_out_ready = 1'b0, u1_out_carry, u1_out_ovf, u1_busy;
  logic [7:0]  u1_out_res;

  byte_serial_add_ctrl #(.N_BYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  byte_serial_add_ctrl #(.N_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .in_a(u1_in_a), .in_b(u1_in_b), .in_sub(u1_in_sub),
    .add_a(u1_add_a), .add_b(u1_add_b), .add_cin(u1_add_cin),
    .add_sum(u1_add_sum), .add_cout(u1_add_cout),
    .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_res(u1_out_res),
    .out_carry(u1_out_carry), .out_ovf(u1_out_ovf), .busy(u1_busy)
  );

  // Registered 8-bit adder beside the 4-byte instance (1-cycle latency).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {add_cout, add_sum} <= '0;
    else      {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  end

  // Registered 8-bit adder beside the 1-byte instance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {u1_add_cout, u1_add_sum} <= '0;
    else      {u1_add_cout, u1_add_sum} <= {1'b0, u1_add_a} + {1'b0, u1_add_b} + {8'd0, u1_add_cin};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, scramble inputs right after the accept edge, and
  // count clock edges (accept edge included) until out_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    chk("rst_res", {out_res, out_carry, out_ovf}, 0);
    @(negedge clk); rst = 1'b1;
    // out_ready while idle is ignored
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("idle_ready_ign", {in_ready, out_valid}, 2'b10);

    // 1: carry ripples across a byte boundary
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    chk("t1_lat", lat, 6);
    chk("t1_res", out_res, 32'h0000_0100);
    chk("t1_flags", {out_carry, out_ovf}, 2'b00);
    accept_result();

    // 2: full-width wrap
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    chk("t2_res", out_res, 32'h0000_0000);
    chk("t2_flags", {out_carry, out_ovf}, 2'b10);
    accept_result();

    // 3a: signed overflow on add
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    chk("t3a_res", out_res, 32'h8000_0000);
    chk("t3a_flags", {out_carry, out_ovf}, 2'b01);
    accept_result();

    // 3b: subtract with borrow
    run_op(32'd5, 32'd7, 1'b1, lat);
    chk("t3b_res", out_res, 32'hFFFF_FFFE);
    chk("t3b_flags", {out_carry, out_ovf}, 2'b00);
    accept_result();
    chk("t3b_idle_hold", out_res, 32'hFFFF_FFFE);

    // 4: backpressure
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", {out_valid, in_ready, busy}, 3'b101);
      chk("t4_hold_res", out_res, 32'h2345_6789);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("t4_release", {in_ready, out_valid}, 2'b10);
    chk("t4_idle_res", out_res, 32'h2345_6789);

    // 5: asynchronous reset in the middle of RUN
    @(negedge clk);
    in_a = 32'h1122_3344; in_b = 32'h0000_0000; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_pre_add_a", add_a, 8'h22);
    chk("t5_pre_busy", busy, 1);
    @(negedge clk); rst = 1'b0; #1;
    chk("t5_rst_state", {in_ready, busy, out_valid}, 3'b100);
    chk("t5_rst_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t5_no_valid", out_valid, 0);
    end
    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, lat);
    chk("t5_post_lat", lat, 6);
    chk("t5_post_res", out_res, 32'h0E0E_0E0E);
    chk("t5_post_flags", {out_carry, out_ovf}, 2'b10);
    accept_result();

    // 6: single-byte instance, cin=sub is the only carry source
    @(negedge clk);
    u1_in_a = 8'h80; u1_in_b = 8'h01; u1_in_sub = 1'b1; u1_in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    u1_in_valid = 1'b0; u1_in_a = 8'h00; u1_in_b = 8'hFF; u1_in_sub = 1'b0;
    while (!u1_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t6_lat", lat, 3);
    chk("t6_res", u1_out_res, 8'h7F);
    chk("t6_flags", {u1_out_carry, u1_out_ovf}, 2'b11);
    @(negedge clk); u1_out_ready = 1'b1;
    @(posedge clk); #1; u1_out_ready = 1'b0;
    chk("t6_release", {u1_in_ready, u1_out_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
